// File: rtl/siso_shift_ctrl_if.sv
// siso_shift_ctrl_if: producer / shift-register side bundle
// for the serial-in serial-out sequencer.
interface siso_shift_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  logic             i_valid;
  logic [WIDTH-1:0] i_data;
  logic             i_abort;
  logic [DEPTH-1:0] i_q;
  logic             o_ready;
  logic             o_sd;
  logic             o_shift_en;
  logic             o_busy;
  logic [DEPTH-1:0] o_rx_data;
  logic             o_done;
  logic             o_aborted;

  modport master (
    output i_valid,
    output i_data,
    output i_abort,
    output i_q,
    input  o_ready,
    input  o_sd,
    input  o_shift_en,
    input  o_busy,
    input  o_rx_data,
    input  o_done,
    input  o_aborted
  );

  modport slave (
    input  i_valid,
    input  i_data,
    input  i_abort,
    input  i_q,
    output o_ready,
    output o_sd,
    output o_shift_en,
    output o_busy,
    output o_rx_data,
    output o_done,
    output o_aborted
  );
endinterface

// File: rtl/siso_shift_ctrl.sv
// siso_shift_ctrl: serialises a parallel word into a SISO
// register, then captures its tap. MSB-first: SISO_CTRL_MSB_FIRST_EN.
module siso_shift_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic              i_clk,
  input logic              i_rst,
  siso_shift_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CAPTURE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0] buf_q;
  logic [WIDTH-1:0] buf_d;
  logic [DEPTH-1:0] rx_q;
  logic [DEPTH-1:0] rx_d;
  logic             sd_q;
  logic             sd_d;
  logic             en_q;
  logic             en_d;
  logic             rdy_q;
  logic             busy_q;
  logic             done_q;
  logic             done_d;
  logic             abt_q;
  logic             abt_d;

  // bit k of the serial stream for word w
  function automatic logic pick(
    input logic [WIDTH-1:0] w,
    input logic [CNT_W-1:0] k
  );
    logic [WIDTH-1:0] s;
`ifdef SISO_CTRL_MSB_FIRST_EN
    s = w >> (LAST - k);
`else
    s = w >> k;
`endif
    return s[0];
  endfunction

  assign cnt_nxt = cnt_q + 1'b1;

  // next state and next registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    rx_d    = rx_q;
    sd_d    = 1'b0;
    en_d    = 1'b0;
    done_d  = 1'b0;
    abt_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          buf_d   = bus.i_data;
          cnt_d   = '0;
          state_d = SHIFT;
          sd_d    = pick(bus.i_data, '0);
          en_d    = 1'b1;
        end
      end
      SHIFT: begin
        if (bus.i_abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          abt_d   = 1'b1;
        end else if (cnt_q == LAST) begin
          state_d = CAPTURE;
          cnt_d   = cnt_nxt;
        end else begin
          cnt_d = cnt_nxt;
          sd_d  = pick(buf_q, cnt_nxt);
          en_d  = 1'b1;
        end
      end
      CAPTURE: begin
        rx_d    = bus.i_q;
        done_d  = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // state and output registers, synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      rx_q    <= '0;
      sd_q    <= 1'b0;
      en_q    <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      rx_q    <= rx_d;
      sd_q    <= sd_d;
      en_q    <= en_d;
      rdy_q   <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
      abt_q   <= abt_d;
    end
  end

  assign bus.o_ready    = rdy_q;
  assign bus.o_sd       = sd_q;
  assign bus.o_shift_en = en_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_rx_data  = rx_q;
  assign bus.o_done     = done_q;
  assign bus.o_aborted  = abt_q;

endmodule
